// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 burst demux scheduler: FSM states, channel
// count and the round-robin channel search.
package demux_pkg;

    localparam int NCH = 4;

    typedef enum logic {IDLE, BURST} state_t;

    // Returns the first enabled channel strictly after ptr, wrapping mod NCH.
    // Scanning from the farthest offset down leaves the nearest hit in r; an
    // offset of NCH lands back on ptr, so a lone enabled current channel is re-granted.
    function automatic logic [1:0] next_en(input logic [1:0] ptr, input logic [NCH-1:0] mask);
        logic [1:0] idx;
        logic [1:0] r;
        r = ptr;
        for (int k = NCH; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (mask[idx]) r = idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux1_4_sched_if.sv
// Stream bundle for demux1_4_sched: one input stream and four output channels.
// The i_last port exists only when DEMUX_LAST_EN is defined.
interface demux1_4_sched_if #(
    parameter int DW = 8
);
    logic [DW-1:0]   i;
    logic            i_valid;
    logic            i_ready;
`ifdef DEMUX_LAST_EN
    logic            i_last;
`endif
    logic [4*DW-1:0] y;
    logic [3:0]      y_valid;
    logic [3:0]      y_ready;

`ifdef DEMUX_LAST_EN
    modport master (output i, i_valid, i_last, y_ready, input i_ready, y, y_valid);
    modport slave  (input i, i_valid, i_last, y_ready, output i_ready, y, y_valid);
`else
    modport master (output i, i_valid, y_ready, input i_ready, y, y_valid);
    modport slave  (input i, i_valid, y_ready, output i_ready, y, y_valid);
`endif
endinterface

// File: rtl/demux1_4_hold.sv
// One-entry output holding register; expands the stored destination into
// one-hot valid and places the data in the matching output slot.
module demux1_4_hold #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DW-1:0]   din,
    input  logic [1:0]      dst,
    input  logic [3:0]      y_ready,
    output logic [4*DW-1:0] y,
    output logic [3:0]      y_valid,
    output logic            hv,
    output logic [1:0]      hs
);
    logic [DW-1:0] hd;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the data register is reset too, so y reads zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd <= '0;
            hs <= '0;
            hv <= 1'b0;
        end else if (load) begin
            // An accept wins over a same-cycle drain: overwrite and stay valid.
            hd <= din;
            hs <= dst;
            hv <= 1'b1;
        end else if (hv && y_ready[hs]) begin
            hv <= 1'b0;
        end
    end

    // NOTE: defaults first, so no path through the block leaves an output
    // unassigned and infers a latch.
    always_comb begin
        y                   = '0;
        y_valid             = '0;
        y[int'(hs)*DW +: DW] = hd;
        y_valid[hs]         = hv;
    end

endmodule

// File: rtl/demux1_4_sched.sv
// Round-robin burst scheduler driving a 1:4 demux through a holding stage.
// Optional early burst termination on i_last is enabled by DEMUX_LAST_EN.
module demux1_4_sched #(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       chan_en,
    demux1_4_sched_if.slave  io,
    output logic [1:0]       s,
    output logic             busy
);
    import demux_pkg::state_t;
    import demux_pkg::next_en;

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n, s_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          hv;
    logic [1:0]    hs;
    logic          accept;
    logic          last;

    // i_ready depends only on state and the holding stage, never on i_valid.
    assign io.i_ready = (state == demux_pkg::BURST) && (!hv || io.y_ready[hs]);
    assign accept     = io.i_valid && io.i_ready;
    assign busy       = (state == demux_pkg::BURST);

`ifdef DEMUX_LAST_EN
    assign last = (cnt == CNT_LAST) || io.i_last;
`else
    assign last = (cnt == CNT_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= demux_pkg::IDLE;
            ptr   <= 2'd3;
            s     <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            s     <= s_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        s_n     = s;
        cnt_n   = cnt;
        case (state)
            demux_pkg::IDLE: begin
                if (|chan_en) begin
                    s_n     = next_en(ptr, chan_en);
                    ptr_n   = s_n;
                    cnt_n   = '0;
                    state_n = demux_pkg::BURST;
                end
            end
            demux_pkg::BURST: begin
                if (accept) begin
                    if (last) begin
                        // Re-grant in the accepting cycle so bursts run back to back.
                        cnt_n = '0;
                        if (|chan_en) begin
                            s_n   = next_en(s, chan_en);
                            ptr_n = s_n;
                        end else begin
                            state_n = demux_pkg::IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = demux_pkg::IDLE;
        endcase
    end

    demux1_4_hold #(.DW(DW)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .din     (io.i),
        .dst     (s),
        .y_ready (io.y_ready),
        .y       (io.y),
        .y_valid (io.y_valid),
        .hv      (hv),
        .hs      (hs)
    );

endmodule

// File: tb/tb_demux1_4_sched.sv
// Directed self-checking bench for demux1_4_sched (DW=8, BURST=4); the
// early-termination case runs only when DEMUX_LAST_EN is defined.
module tb_demux1_4_sched;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] chan_en;
    logic [1:0] s;
    logic       busy;

    demux1_4_sched_if #(.DW(DW)) bus ();

    demux1_4_sched #(.DW(DW), .BURST(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .chan_en (chan_en),
        .io      (bus.slave),
        .s       (s),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Output transfer log, filled whenever y_valid && y_ready on a channel.
    int         cap_ch[$];
    logic [7:0] cap_d[$];
    int         cap_cyc[$];
    logic [3:0] seen_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            seen_valid = seen_valid | bus.y_valid;
            for (int k = 0; k < 4; k++) begin
                if (bus.y_valid[k] && bus.y_ready[k]) begin
                    cap_ch.push_back(k);
                    cap_d.push_back(bus.y[k*DW +: DW]);
                    cap_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic apply_reset();
        rst         = 1'b1;
        chan_en     = 4'b0000;
        bus.i       = '0;
        bus.i_valid = 1'b0;
        bus.y_ready = 4'b0000;
`ifdef DEMUX_LAST_EN
        bus.i_last  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cap_ch.delete();
        cap_d.delete();
        cap_cyc.delete();
        seen_valid = 4'b0000;
    endtask

    // Streams n beats base, base+1, ... and gives up after budget cycles.
    task automatic send(input int n, input logic [7:0] base, input int budget);
        int   sent = 0;
        int   t = 0;
        logic acc;
        bus.i_valid = 1'b1;
        bus.i       = base;
        while (sent < n && t < budget) begin
            @(negedge clk);
            acc = bus.i_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                bus.i = base + 8'(sent);
            end
            t++;
        end
        bus.i_valid = 1'b0;
        check("send_beats", 64'(sent), 64'(n));
    endtask

    task automatic check_log(input string tag, input int idx, input int ch, input logic [7:0] d);
        if (idx < cap_ch.size()) begin
            check({tag, "_ch"}, 64'(cap_ch[idx]), 64'(ch));
            check({tag, "_data"}, 64'(cap_d[idx]), 64'(d));
        end else begin
            check({tag, "_missing"}, 64'(idx), 64'(cap_ch.size()));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        apply_reset();
        check("rst_y_valid", 64'(bus.y_valid), 64'(0));
        check("rst_y", 64'(bus.y), 64'(0));
        check("rst_i_ready", 64'(bus.i_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_s", 64'(s), 64'(0));

        // All channels enabled: four back-to-back bursts, one beat per cycle
        chan_en     = 4'b1111;
        bus.y_ready = 4'b1111;
        send(16, 8'd0, 40);
        repeat (2) @(posedge clk);
        check("rr_count", 64'(cap_ch.size()), 64'(16));
        for (int j = 0; j < 16; j++) begin
            check_log("rr", j, j / 4, 8'(j));
            if (j < cap_cyc.size()) check("rr_rate", 64'(cap_cyc[j] - cap_cyc[0]), 64'(j));
        end

        // Sparse mask 1010: channels 1 then 3 only
        apply_reset();
        chan_en     = 4'b1010;
        bus.y_ready = 4'b1111;
        send(8, 8'h20, 30);
        repeat (2) @(posedge clk);
        check("sparse_count", 64'(cap_ch.size()), 64'(8));
        for (int j = 0; j < 8; j++) check_log("sparse", j, (j < 4) ? 1 : 3, 8'h20 + 8'(j));
        check("sparse_no_ch0", 64'(seen_valid[0]), 64'(0));
        check("sparse_no_ch2", 64'(seen_valid[2]), 64'(0));

        // Backpressure on channel 0 for 5 cycles
        apply_reset();
        chan_en     = 4'b0001;
        bus.y_ready = 4'b0000;
        bus.i_valid = 1'b1;
        bus.i       = 8'hA0;
        @(posedge clk); #1;
        check("bp_grant_ready", 64'(bus.i_ready), 64'(1));
        @(posedge clk); #1;
        bus.i = 8'hA1;
        check("bp_held_valid", 64'(bus.y_valid), 64'(4'b0001));
        check("bp_held_data", 64'(bus.y[7:0]), 64'(8'hA0));
        check("bp_stall_ready", 64'(bus.i_ready), 64'(0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_stall_ready", 64'(bus.i_ready), 64'(0));
            check("bp_stable_data", 64'(bus.y[7:0]), 64'(8'hA0));
        end
        bus.y_ready = 4'b0001;
        #1;
        check("bp_release_ready", 64'(bus.i_ready), 64'(1));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("bp_next_valid", 64'(bus.y_valid), 64'(4'b0001));
        check("bp_next_data", 64'(bus.y[7:0]), 64'(8'hA1));
        @(posedge clk); #1;
        check("bp_drained", 64'(bus.y_valid), 64'(0));

        // Mask dropped at the second beat: burst completes, then IDLE
        apply_reset();
        chan_en     = 4'b1111;
        bus.y_ready = 4'b1111;
        bus.i_valid = 1'b1;
        bus.i       = 8'h40;
        @(posedge clk); #1;
        check("off_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        bus.i   = 8'h41;
        chan_en = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.i = bus.i + 8'd1;
        end
        check("off_idle_busy", 64'(busy), 64'(0));
        check("off_idle_ready", 64'(bus.i_ready), 64'(0));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("off_still_idle", 64'(busy), 64'(0));
        check("off_count", 64'(cap_ch.size()), 64'(4));
        for (int j = 0; j < 4; j++) check_log("off", j, 0, 8'h40 + 8'(j));

`ifdef DEMUX_LAST_EN
        // Early end of channel 0's burst on beat 1
        apply_reset();
        chan_en     = 4'b1111;
        bus.y_ready = 4'b1111;
        bus.i_valid = 1'b1;
        bus.i       = 8'h50;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i      = 8'h51;
        bus.i_last = 1'b1;
        @(posedge clk); #1;
        bus.i      = 8'h52;
        bus.i_last = 1'b0;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        check("last_count", 64'(cap_ch.size()), 64'(3));
        check_log("last", 0, 0, 8'h50);
        check_log("last", 1, 0, 8'h51);
        check_log("last", 2, 1, 8'h52);
`endif

        // Asynchronous reset while a beat is held on channel 1
        apply_reset();
        chan_en     = 4'b0010;
        bus.i_valid = 1'b1;
        bus.i       = 8'h60;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("ar_pre_valid", 64'(bus.y_valid), 64'(4'b0010));
        check("ar_pre_s", 64'(s), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("ar_y_valid", 64'(bus.y_valid), 64'(0));
        check("ar_s", 64'(s), 64'(0));
        check("ar_busy", 64'(busy), 64'(0));
        check("ar_y", 64'(bus.y), 64'(0));
        @(posedge clk); #1;
        rst         = 1'b0;
        chan_en     = 4'b1111;
        bus.y_ready = 4'b1111;
        bus.i_valid = 1'b1;
        bus.i       = 8'h61;
        @(posedge clk); #1;
        check("ar_regrant_s", 64'(s), 64'(0));
        check("ar_regrant_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("ar_first_valid", 64'(bus.y_valid), 64'(4'b0001));
        check("ar_first_data", 64'(bus.y[7:0]), 64'(8'h61));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
